// File: rtl/ip_amba_ahb5_pkg.sv
// Shared AHB5 encodings for the arbiter slice: transfer types, burst types
// and the helper that turns a burst type into a beat count.
package ip_amba_ahb5_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Wide enough to hold the beats remaining in a 16-beat burst.
  localparam int BURST_CNT_W = 4;

  // Beats still to come after the NONSEQ beat of a burst. Undefined-length
  // INCR bursts count as single beats so they never block a handover.
  function automatic logic [BURST_CNT_W-1:0] burstBeatsMinusOne(input logic [2:0] burst);
    logic [BURST_CNT_W-1:0] beats;
    beats = '0;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ip_amba_ahb5_rr_picker.sv
// Round-robin search: returns the first set request strictly after the
// pointer, wrapping around so the pointer's own master is considered last.
module ip_amba_ahb5_rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  winner_o,
  output logic          valid_o
);

  logic [PW-1:0] candIdx;

  // Walk the candidates in priority order and latch the first requester.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    candIdx  = '0;
    for (int off = 1; off <= N; off++) begin
      candIdx = PW'((int'(ptr_i) + off) % N);
      if (!valid_o && req_i[candIdx]) begin
        winner_o[candIdx] = 1'b1;
        valid_o           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_amba_ahb5_arbiter.sv
// AHB5 bus arbiter: registered one-hot grant with round-robin fairness,
// burst and locked-sequence protection, and default-master parking.
// The grant runs one HREADY-qualified cycle ahead of HMASTER.
module ip_amba_ahb5_arbiter
  import ip_amba_ahb5_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HBURST,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic                           HMASTLOCK
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_IDX    = MW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]          master_q;
  logic                   mastLock_q;

  logic [NUM_MASTERS-1:0] pickWinner;
  logic                   pickValid;
  logic [MW-1:0]          pickIdx;
  logic [MW-1:0]          ownerIdx;
  logic                   lockHeld;
  logic                   handoverOk;

  ip_amba_ahb5_rr_picker #(
    .N  (NUM_MASTERS),
    .PW (MW)
  ) uPicker (
    .req_i    (HBUSREQ),
    .ptr_i    (ptr_q),
    .winner_o (pickWinner),
    .valid_o  (pickValid)
  );

  // Encode the current one-hot grant and the picker's winner as indices.
  always_comb begin
    ownerIdx = '0;
    pickIdx  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        ownerIdx = MW'(i);
      end
      if (pickWinner[i]) begin
        pickIdx = MW'(i);
      end
    end
  end

  // Track beats left in the owner's burst; IDLE ends a burst early, BUSY pauses it.
  always_comb begin
    cnt_d = cnt_q;
    if (HREADY) begin
      case (HTRANS)
        HTRANS_NONSEQ: cnt_d = burstBeatsMinusOne(HBURST);
        HTRANS_SEQ:    if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        HTRANS_IDLE:   cnt_d = '0;
        default:       cnt_d = cnt_q;
      endcase
    end
  end

  // Handover is allowed once the burst is on its last beat and no lock is held;
  // using the updated count lets the grant move while the final beat is issued.
  always_comb begin
    lockHeld   = HLOCK[ownerIdx] & HBUSREQ[ownerIdx];
    handoverOk = HREADY && !lockHeld && (cnt_d <= 4'd1);
  end

  // Choose the next grant; parking on the default master leaves the pointer alone.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (handoverOk) begin
      if (pickValid) begin
        grant_d = pickWinner;
        ptr_d   = pickIdx;
      end else begin
        grant_d = DEF_ONEHOT;
      end
    end
  end

  // Register all arbitration state; reset abandons any burst or lock in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q    <= DEF_ONEHOT;
      ptr_q      <= DEF_IDX;
      cnt_q      <= '0;
      master_q   <= DEF_IDX;
      mastLock_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (HREADY) begin
        master_q   <= ownerIdx;
        mastLock_q <= HLOCK[ownerIdx];
      end
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastLock_q;

endmodule

// File: tb/tb_ip_amba_ahb5_arbiter.sv
// Testbench for ip_amba_ahb5_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural arbitration model through a
// scoreboard queue.
module tb_ip_amba_ahb5_arbiter;

  localparam int NM  = 4;
  localparam int DEF = 0;
  localparam int MW  = 2;

  logic          HCLK;
  logic          HRESET;
  logic [NM-1:0] HBUSREQ;
  logic [NM-1:0] HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [NM-1:0] HGRANT;
  logic [MW-1:0] HMASTER;
  logic          HMASTLOCK;

  typedef struct {
    logic [NM-1:0] grant;
    logic [MW-1:0] master;
    logic          mlock;
  } exp_t;

  exp_t expQ[$];

  int testsRun    = 0;
  int testsFailed = 0;

  int mOwner;
  int mLast;
  int mBeatsLeft;
  int mHmaster;
  bit mHmastlock;

  ip_amba_ahb5_arbiter #(
    .NUM_MASTERS    (NM),
    .DEFAULT_MASTER (DEF)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  // Free-running bus clock.
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Guard against a stuck simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Total beats of a fixed-length burst; SINGLE and INCR behave as one beat.
  function automatic int burstBeats(input logic [2:0] burst);
    int table_[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
    return table_[burst];
  endfunction

  // Advance the reference model across one clock edge with the given inputs.
  task automatic modelEdge(input logic rst, input logic [NM-1:0] req, input logic [NM-1:0] lock,
                           input logic [1:0] trans, input logic [2:0] burst, input logic ready);
    int newBeats;
    int newOwner;
    int newLast;
    int found;
    int cand;
    bit locked;
    if (rst) begin
      mOwner     = DEF;
      mLast      = DEF;
      mBeatsLeft = 0;
      mHmaster   = DEF;
      mHmastlock = 0;
      return;
    end
    newBeats = mBeatsLeft;
    if (ready) begin
      if (trans == 2'd2) newBeats = burstBeats(burst) - 1;
      else if (trans == 2'd3 && mBeatsLeft > 0) newBeats = mBeatsLeft - 1;
      else if (trans == 2'd0) newBeats = 0;
    end
    locked   = lock[mOwner] && req[mOwner];
    newOwner = mOwner;
    newLast  = mLast;
    if (ready && !locked && newBeats <= 1) begin
      found = -1;
      for (int k = 1; k <= NM; k++) begin
        cand = (mLast + k) % NM;
        if (found < 0 && req[cand]) found = cand;
      end
      if (found >= 0) begin
        newOwner = found;
        newLast  = found;
      end else begin
        newOwner = DEF;
      end
    end
    if (ready) begin
      mHmaster   = mOwner;
      mHmastlock = lock[mOwner];
    end
    mOwner     = newOwner;
    mLast      = newLast;
    mBeatsLeft = newBeats;
  endtask

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic applyStimulus(input logic rst, input logic [NM-1:0] req, input logic [NM-1:0] lock,
                               input logic [1:0] trans, input logic [2:0] burst, input logic ready);
    exp_t e;
    @(negedge HCLK);
    HRESET  = rst;
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = ready;
    modelEdge(rst, req, lock, trans, burst, ready);
    e.grant  = NM'(1) << mOwner;
    e.master = MW'(mHmaster);
    e.mlock  = mHmastlock;
    expQ.push_back(e);
  endtask

  // Apply one cycle and wait until its outputs are settled past the edge.
  task automatic step(input logic rst, input logic [NM-1:0] req, input logic [NM-1:0] lock,
                      input logic [1:0] trans, input logic [2:0] burst, input logic ready);
    applyStimulus(rst, req, lock, trans, burst, ready);
    @(posedge HCLK);
    #2;
  endtask

  // Monitor: after every edge pop the pending expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sb_grant",     32'(HGRANT),      32'(e.grant));
        checkOutput("sb_hmaster",   32'(HMASTER),     32'(e.master));
        checkOutput("sb_hmastlock", 32'(HMASTLOCK),   32'(e.mlock));
        checkOutput("sb_onehot",    32'($onehot(HGRANT)), 32'd1);
      end
    end
  end

  // Directed scenarios, then random traffic.
  initial begin
    HRESET  = 1'b1;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = 2'd0;
    HBURST  = 3'd0;
    HREADY  = 1'b1;

    // Reset held for two cycles.
    step(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
    step(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
    checkOutput("reset_grant",     32'(HGRANT),    32'h1);
    checkOutput("reset_hmaster",   32'(HMASTER),   32'h0);
    checkOutput("reset_hmastlock", 32'(HMASTLOCK), 32'h0);

    // Round robin with all masters requesting single transfers.
    step(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1);
    checkOutput("rr_grant1", 32'(HGRANT), 32'h2);
    step(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1);
    checkOutput("rr_grant2", 32'(HGRANT), 32'h4);
    step(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1);
    checkOutput("rr_grant3", 32'(HGRANT), 32'h8);
    step(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1);
    checkOutput("rr_grant0", 32'(HGRANT), 32'h1);

    // Burst hold: master 1 runs INCR4 while master 2 waits.
    step(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1);
    checkOutput("burst_setup_grant", 32'(HGRANT), 32'h2);
    step(0, 4'b0110, 4'b0000, 2'd2, 3'd3, 1);
    checkOutput("burst_hold_nonseq", 32'(HGRANT), 32'h2);
    step(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1);
    checkOutput("burst_hold_seq1", 32'(HGRANT), 32'h2);
    step(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1);
    checkOutput("burst_handover_grant", 32'(HGRANT),  32'h4);
    checkOutput("burst_handover_hmst",  32'(HMASTER), 32'h1);
    step(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1);
    checkOutput("burst_hmaster_follow", 32'(HMASTER), 32'h2);

    // Wait states with master 3 pending.
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b1000, 4'b0000, 2'd0, 3'd0, 0);
    end
    step(0, 4'b1000, 4'b0000, 2'd0, 3'd0, 1);
    checkOutput("wait_release_grant", 32'(HGRANT), 32'h8);

    // Locked sequence by master 2 against full contention.
    step(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1);
    checkOutput("lock_setup_grant", 32'(HGRANT), 32'h4);
    for (int i = 0; i < 10; i++) begin
      step(0, 4'b1111, 4'b0100, 2'd2, 3'd0, 1);
      checkOutput("lock_hold_grant", 32'(HGRANT),    32'h4);
      checkOutput("lock_hmastlock",  32'(HMASTLOCK), 32'h1);
    end
    step(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1);
    checkOutput("lock_release_grant", 32'(HGRANT), 32'h8);

    // Early termination of INCR8 and default parking.
    step(0, 4'b0011, 4'b0000, 2'd2, 3'd5, 1);
    checkOutput("incr8_hold", 32'(HGRANT), 32'h8);
    step(0, 4'b0011, 4'b0000, 2'd3, 3'd5, 1);
    checkOutput("incr8_hold_seq", 32'(HGRANT), 32'h8);
    step(0, 4'b0011, 4'b0000, 2'd0, 3'd5, 1);
    checkOutput("incr8_abort_grant", 32'(HGRANT), 32'h1);
    step(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1);
    checkOutput("park_pre_grant", 32'(HGRANT), 32'h2);
    step(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
    checkOutput("park_default_grant", 32'(HGRANT), 32'h1);

    // Reset in the middle of a burst abandons it.
    step(0, 4'b0110, 4'b0000, 2'd2, 3'd7, 1);
    step(1, 4'b0110, 4'b0000, 2'd3, 3'd7, 1);
    checkOutput("midburst_reset_grant", 32'(HGRANT), 32'h1);
    step(0, 4'b0110, 4'b0000, 2'd3, 3'd7, 1);
    checkOutput("post_reset_rr_grant", 32'(HGRANT), 32'h2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic          rRst;
      logic [NM-1:0] rReq;
      logic [NM-1:0] rLock;
      logic [1:0]    rTrans;
      logic [2:0]    rBurst;
      logic          rReady;
      rRst   = ($urandom_range(0, 49) == 0);
      rReq   = NM'($urandom_range(0, 15));
      rLock  = ($urandom_range(0, 3) == 0) ? NM'($urandom_range(0, 15)) : '0;
      rTrans = 2'($urandom_range(0, 3));
      rBurst = 3'($urandom_range(0, 7));
      rReady = ($urandom_range(0, 3) != 0);
      applyStimulus(rRst, rReq, rLock, rTrans, rBurst, rReady);
    end
    @(posedge HCLK);
    #2;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
